// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle, start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH[WIDTH-1:0];

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic             op_r;
  logic [WIDTH-1:0] opnd;    // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] acc_hi;  // partial product upper half / remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier being consumed / quotient
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   sum, shifted, trial;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    step_hi = '0;
    step_lo = '0;
    if (!op_r) begin
      // carry of the add shifts into the top of the accumulator
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      step_hi = trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = shifted[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_r    <= op;
            opnd    <= op ? b : a;
            acc_hi  <= '0;
            acc_lo  <= op ? a : b;
            cnt     <= CNT_INIT;
            divzero <= 1'b0;
            if (op && (b == '0)) begin
              state   <= DONE;
              hi      <= a;
              lo      <= '1;
              divzero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == 1) begin
            state <= DONE;
            hi    <= step_hi;
            lo    <= step_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, handshake corner cases,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  int nchk = 0;
  int nerr = 0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model from plain arithmetic
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    int p;
    if (!o) begin
      p = int'(x) * int'(y);
      eh = W'(p >> W); el = W'(p); ed = 1'b0;
    end else if (y == 0) begin
      eh = x; el = '1; ed = 1'b1;
    end else begin
      eh = x % y; el = x / y; ed = 1'b0;
    end
  endtask

  // Full operation with per-cycle handshake checks; expected from model or table.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    int lat;
    lat = ed ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      if (c < lat) begin
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        if (c == 1) begin
          chk("hi_hold", hi, prev_hi);
          chk("lo_hold", lo, prev_lo);
          chk("dz_cleared", divzero, 0);
        end
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("divzero", divzero, ed);
      end
    end
    prev_hi = eh; prev_lo = el;
  endtask

  task automatic do_model_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el; logic ed;
    model(o, x, y, eh, el, ed);
    do_op(o, x, y, eh, el, ed);
  endtask

  vec_t vt[7];

  initial begin
    logic [W-1:0] eh, el; logic ed;
    int seen;
    vt[0] = '{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0};
    vt[1] = '{1'b0, 8'hFF,  8'hFF,  8'hFE, 8'h01, 1'b0};
    vt[2] = '{1'b0, 8'h00,  8'hFF,  8'h00, 8'h00, 1'b0};
    vt[3] = '{1'b1, 8'd100, 8'd7,   8'h02, 8'h0E, 1'b0};
    vt[4] = '{1'b1, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0};
    vt[5] = '{1'b1, 8'h5A,  8'h00,  8'h5A, 8'hFF, 1'b1};
    vt[6] = '{1'b1, 8'd200, 8'd3,   8'h02, 8'h42, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", divzero, 0);
    reset = 1'b0;

    // vector 5 (divide by zero) is followed by vector 6, whose cycle 1 checks divzero clears
    for (int i = 0; i < 7; i++)
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dz);

    // start re-pulsed at cycle 3 with other operands: must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'd21; b = 8'd6;
    @(negedge clk); start = 1'b0;                      // cycle 1
    @(negedge clk);                                     // cycle 2
    @(negedge clk); start = 1'b1; op = 1'b1; a = 8'd99; b = 8'd4;  // cycle 3
    @(negedge clk); start = 1'b0;                      // cycle 4
    repeat (5) @(negedge clk);                          // cycle 9
    chk("ign_done", done, 1);
    chk("ign_hi", hi, 8'h00);
    chk("ign_lo", lo, 8'd126);
    @(negedge clk);
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_done", done, 0);
    prev_hi = 8'h00; prev_lo = 8'd126;

    // back-to-back: start held during done cycle
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd250; b = 8'd11;
    @(negedge clk); start = 1'b0;
    repeat (W) @(negedge clk);                          // cycle 9
    chk("b2b_done1", done, 1);
    chk("b2b_lo1", lo, 8'd22);
    chk("b2b_hi1", hi, 8'd8);
    start = 1'b1; op = 1'b0; a = 8'd17; b = 8'd15;
    @(negedge clk); start = 1'b0; a = 8'h33; b = 8'h44;
    chk("b2b_busy2", busy, 1);
    chk("b2b_hold_lo", lo, 8'd22);
    repeat (W - 1) @(negedge clk);
    chk("b2b_notyet", done, 0);
    @(negedge clk);                                     // 9 cycles after first done
    chk("b2b_done2", done, 1);
    chk("b2b_hi2", hi, 8'h00);
    chk("b2b_lo2", lo, 8'hFF);
    prev_hi = 8'h00; prev_lo = 8'hFF;

    // reset during cycle 4 of a multiply
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'hC3; b = 8'h5D;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);                          // cycle 4
    reset = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_hi", hi, 0);
    chk("mr_lo", lo, 0);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mr_no_done", seen, 0);
    prev_hi = '0; prev_lo = '0;
    do_model_op(1'b0, 8'hC3, 8'h5D);

    // randomized operations, occasional zero divisor
    for (int i = 0; i < 40; i++) begin
      logic o; logic [W-1:0] x, y;
      o = 1'($urandom);
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_model_op(o, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
